key_filter: RTL
===============

Name: key_filter

Overview:
- Debounces the raw push-button inputs and conditions them for the flowing-light stage.
- Delivers clean level, press, release and long-press signals per key, plus a registered 2-bit frequency select.
- Sits directly upstream of the LED-shifting stage: key_press[0] feeds its start/stop button input; freq_sel feeds its freq_set input.

Parameters:
- NUM_KEYS, 4, number of independent key channels (1..8).
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a level change (10 ms at 100 MHz); must be >= 1.
- LONG_CYCLES, 100000000, cycles held in PRESSED before key_long fires (1 s at 100 MHz); must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 0, 1 = raw key reads 0 when pressed; the block inverts after synchronisation.
- FREQ_KEY, 1, index of the key whose press advances freq_sel; must be < NUM_KEYS.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- key_in  input  NUM_KEYS  raw asynchronous key pins
- key_level  output  NUM_KEYS  debounced pressed state, 1 = pressed
- key_press  output  NUM_KEYS  one-cycle pulse on accepted press
- key_release  output  NUM_KEYS  one-cycle pulse on accepted release
- key_long  output  NUM_KEYS  one-cycle pulse when a press has lasted LONG_CYCLES
- freq_sel  output  2  frequency select; advances on key_press[FREQ_KEY]

Behaviour:
- Reset:
  - All outputs 0; freq_sel = 2'b00.
  - Synchroniser flops reset to the inactive (not-pressed) level.
  - Every channel is in IDLE with counters cleared.
  - Reset mid-filter or mid-press aborts with no pulses emitted.
- Synchroniser:
  - Two-flop synchroniser per key, followed by polarity inversion if ACTIVE_LOW.
  - All logic downstream uses only the synchronised value s.
- Per-channel FSM, states IDLE, PRESS_FILT, PRESSED, REL_FILT:
  - IDLE: s=1 -> PRESS_FILT, deb_cnt=1.
  - PRESS_FILT: s=0 -> IDLE, deb_cnt=0. s=1 with deb_cnt==DEBOUNCE_CYCLES -> PRESSED. Otherwise deb_cnt++.
  - Entering PRESSED: key_level<=1, key_press=1 for exactly one cycle, hold_cnt<=1, long_done<=0.
  - PRESSED: s=0 -> REL_FILT, deb_cnt=1.
  - REL_FILT: s=1 -> PRESSED (bounce, no pulse). s=0 with deb_cnt==DEBOUNCE_CYCLES -> IDLE, key_level<=0, key_release=1 for one cycle. Otherwise deb_cnt++.
- Latency:
  - Raw stable change to the key_level edge, and to the press or release pulse, is exactly DEBOUNCE_CYCLES+2 clk cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no output change.
- Long press:
  - hold_cnt increments every cycle in PRESSED and REL_FILT, saturating at LONG_CYCLES.
  - When hold_cnt reaches LONG_CYCLES and long_done=0, key_long pulses one cycle and long_done<=1.
  - No auto-repeat; at most one key_long per press.
  - A key_long during REL_FILT is legal.
- freq_sel:
  - Increments modulo 4 (11 -> 00 wrap) in the cycle after key_press[FREQ_KEY].
  - key_long and key_release do not affect it.
- Channels are fully independent; simultaneous presses on several keys give simultaneous pulses.
- Width rules:
  - deb_cnt width = clog2(DEBOUNCE_CYCLES+1).
  - hold_cnt width = clog2(LONG_CYCLES+1).
  - Counters never wrap.

Decomposition:
- Shared package key_pkg holds:
  - the state enumeration {IDLE, PRESS_FILT, PRESSED, REL_FILT};
  - a clog2 width helper;
  - default timing constants DEB_10MS_100MHZ and LONG_1S_100MHZ.
- One sub-module, key_filter_ch: synchroniser, FSM and both counters for a single key, instantiated NUM_KEYS times by a generate loop.
- The top level adds freq_sel and the parameter legality checks.

Test Plan (DEBOUNCE_CYCLES=8, LONG_CYCLES=32, NUM_KEYS=2, FREQ_KEY=1):
- Reset released, keys idle for 50 cycles -> all outputs 0, freq_sel=00.
- key_in[0] high and held -> key_press[0] single pulse exactly 10 cycles after the rise; key_level[0]=1 from the same cycle.
- key_in[0] bounces: 3 high, 2 low, 5 high, 1 low, then stable high -> no pulse until 10 cycles after the last rise; exactly one key_press[0].
- key_in[0] held 60 cycles -> exactly one key_long[0], 32 cycles after key_press[0]. Release -> key_release[0] 10 cycles later; key_level[0]=0.
- Five clean presses on key_in[1] -> freq_sel sequence 00, 01, 10, 11, 00, 01; key_press[0] unaffected.
- rst asserted 3 cycles into PRESSED, then released with key still high -> outputs 0 immediately; a fresh key_press only after another DEBOUNCE_CYCLES+2 cycles.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and timing constants for the push-button conditioning block.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        PRESSED    = 2'd2,
        REL_FILT   = 2'd3
    } key_state_e;

    localparam int DEB_10MS_100MHZ = 1000000;
    localparam int LONG_1S_100MHZ  = 100000000;

    // Bits needed to hold values 0..v-1; never less than 1.
    function automatic int clog2w(input longint v);
        int w;
        w = 1;
        for (int i = 1; i < 40; i++) begin
            if ((64'd1 << i) < v) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold counter for long-press.
// Outputs are registered, DEBOUNCE_CYCLES+2 cycles after a stable raw change.
module key_filter_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_10MS_100MHZ,
    parameter int LONG_CYCLES     = LONG_1S_100MHZ,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DW = clog2w(longint'(DEBOUNCE_CYCLES) + 1);
    localparam int HW = clog2w(longint'(LONG_CYCLES) + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES);
    localparam logic          RAW_IDLE = ACTIVE_LOW;

    key_state_e    state_q, state_d;
    logic          sync1_q, sync2_q, s;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d, press_q, press_d;
    logic          release_q, release_d, long_q, long_d;
    logic          holding, accept_press, accept_rel, long_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ RAW_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (s) state_d = PRESS_FILT;
            PRESS_FILT: if (!s) state_d = IDLE;
                        else if (deb_cnt_q == DEB_MAX) state_d = PRESSED;
            PRESSED:    if (!s) state_d = REL_FILT;
            REL_FILT:   if (s) state_d = PRESSED;
                        else if (deb_cnt_q == DEB_MAX) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        deb_cnt_d    = deb_cnt_q;
        accept_press = 1'b0;
        accept_rel   = 1'b0;
        unique case (state_q)
            IDLE:       deb_cnt_d = s ? DW'(1) : '0;
            PRESS_FILT: if (!s) deb_cnt_d = '0;
                        else if (deb_cnt_q == DEB_MAX) begin
                            accept_press = 1'b1;
                            deb_cnt_d    = '0;
                        end else deb_cnt_d = deb_cnt_q + DW'(1);
            PRESSED:    deb_cnt_d = s ? '0 : DW'(1);
            REL_FILT:   if (s) deb_cnt_d = '0;
                        else if (deb_cnt_q == DEB_MAX) begin
                            accept_rel = 1'b1;
                            deb_cnt_d  = '0;
                        end else deb_cnt_d = deb_cnt_q + DW'(1);
            default:    deb_cnt_d = '0;
        endcase

        // A release bounce back into PRESSED keeps the hold count, so one press gives one long pulse.
        holding   = (state_q == PRESSED) || (state_q == REL_FILT);
        long_fire = holding && (hold_cnt_q == LONG_MAX) && !long_done_q;

        hold_cnt_d = hold_cnt_q;
        if (accept_press)                        hold_cnt_d = HW'(1);
        else if (holding && hold_cnt_q != LONG_MAX) hold_cnt_d = hold_cnt_q + HW'(1);

        long_done_d = long_done_q;
        if (accept_press)   long_done_d = 1'b0;
        else if (long_fire) long_done_d = 1'b1;

        level_d = level_q;
        if (accept_press)    level_d = 1'b1;
        else if (accept_rel) level_d = 1'b0;

        press_d   = accept_press;
        release_d = accept_rel;
        long_d    = long_fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_filter.sv
// Debounced key conditioning for NUM_KEYS buttons plus a 2-bit frequency select
// that steps one cycle after each accepted press of key FREQ_KEY.
module key_filter
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEB_10MS_100MHZ,
    parameter int LONG_CYCLES     = LONG_1S_100MHZ,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int FREQ_KEY        = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [1:0]          freq_sel
);

    if (NUM_KEYS < 1 || NUM_KEYS > 8) begin : g_bad_num_keys
        $error("key_filter: NUM_KEYS must be 1..8");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_filter: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("key_filter: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (FREQ_KEY < 0 || FREQ_KEY >= NUM_KEYS) begin : g_bad_freq_key
        $error("key_filter: FREQ_KEY must be < NUM_KEYS");
    end

    logic [NUM_KEYS-1:0] press_w;
    logic [1:0]          freq_sel_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_filter_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .key_i     (key_in[g]),
            .level_o   (key_level[g]),
            .press_o   (press_w[g]),
            .release_o (key_release[g]),
            .long_o    (key_long[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) freq_sel_q <= 2'b00;
        else     freq_sel_q <= freq_sel_q + 2'(press_w[FREQ_KEY]);
    end

    assign key_press = press_w;
    assign freq_sel  = freq_sel_q;

endmodule
